systolic_drain_quant: RTL and testbench

- Downstream consumer of the weight-stationary systolic array's flattened INT32 accumulator bus.
- On a start pulse it snapshots the full N_ROWS x N_COLS psum tile, which frees the array to clr and begin the next tile.
- It then streams one row per handshake, requantized to INT8 (multiply, rounding shift, optional ReLU, saturate), to the output buffer over valid/ready.

---
 rtl/systolic_drain_quant.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_drain_quant.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain_quant.sv
`default_nettype none
// ============================================================================
// Module      : systolic_drain_quant
// Description : Snapshots an N_ROWS x N_COLS INT32 psum tile from the systolic
//               array, then streams it out one row per valid/ready beat,
//               requantized to INT8 (multiply, rounding shift, ReLU, saturate).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_drain_quant #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_ROWS*N_COLS*32-1:0] acc_flat,
  input  logic [15:0]                scale_mult,
  input  logic [4:0]                 scale_shift,
  input  logic                       relu_en,
  output logic                       busy,
  output logic                       done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_COLS*8-1:0]        out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_last,
  output logic [15:0]                sat_count
);

  localparam int ROW_BITS = N_COLS * 32;
  localparam int IDX_W    = ROW_W + 1;
  localparam int CNT_W    = $clog2(N_COLS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [N_ROWS*N_COLS*32-1:0] snapshot_q;
  logic [15:0]                mult_q, mult_d;
  logic [4:0]                 shift_q, shift_d;
  logic                       relu_q, relu_d;
  logic [IDX_W-1:0]           row_idx_q, row_idx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       out_valid_q, out_valid_d;
  logic [N_COLS*8-1:0]        out_data_q, out_data_d;
  logic [ROW_W-1:0]           out_row_q, out_row_d;
  logic                       out_last_q, out_last_d;
  logic [15:0]                sat_count_q, sat_count_d;

  logic [ROW_W-1:0]           w_row_sel;
  logic [ROW_BITS-1:0]        w_row_psum;
  logic [N_COLS*8-1:0]        w_row_q8;
  logic [CNT_W-1:0]           w_clip_cnt;
  logic [16:0]                w_sat_sum;
  logic                       w_capture;

  // Requantize one psum: exact 49-bit product, round-half-up shift, ReLU,
  // then clip to INT8. Bit 8 of the result flags a clip (ReLU is not a clip).
  function automatic logic [8:0] quant8(input logic [31:0] x,
                                        input logic [15:0] m,
                                        input logic [4:0]  sh,
                                        input logic        relu);
    logic signed [48:0] p;
    logic signed [48:0] rnd;
    logic signed [48:0] q;
    logic               clip;
    logic [7:0]         y;
    p    = signed'({{17{x[31]}}, x}) * signed'({33'd0, m});
    rnd  = '0;
    q    = p;
    clip = 1'b0;
    y    = 8'h00;
    if (sh != 5'd0) begin
      rnd = 49'sd1 <<< (sh - 5'd1);
      q   = (p + rnd) >>> sh;
    end
    if (relu && (q < 49'sd0)) begin
      q = '0;
    end
    if (q > 49'sd127) begin
      y    = 8'h7F;
      clip = 1'b1;
    end else if (q < -49'sd128) begin
      y    = 8'h80;
      clip = 1'b1;
    end else begin
      y = q[7:0];
    end
    return {clip, y};
  endfunction

  assign w_row_sel  = row_idx_q[ROW_W-1:0];
  assign w_row_psum = snapshot_q[int'(w_row_sel) * ROW_BITS +: ROW_BITS];
  assign w_capture  = (state_q == S_IDLE) && start;

  // Quantize every lane of the selected snapshot row and count the clips.
  always_comb begin
    logic [8:0] lane;
    w_row_q8   = '0;
    w_clip_cnt = '0;
    for (int c = 0; c < N_COLS; c++) begin
      lane                = quant8(w_row_psum[c*32 +: 32], mult_q, shift_q, relu_q);
      w_row_q8[c*8 +: 8]  = lane[7:0];
      w_clip_cnt          = w_clip_cnt + CNT_W'(lane[8]);
    end
    w_sat_sum = {1'b0, sat_count_q} + 17'(w_clip_cnt);
  end

  // Next-state logic for the drain FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    mult_d      = mult_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    row_idx_d   = row_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    sat_count_d = sat_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mult_d      = scale_mult;
          shift_d     = scale_shift;
          relu_d      = relu_en;
          row_idx_d   = '0;
          sat_count_d = '0;
          busy_d      = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The output register refills whenever it is empty or being emptied.
        if ((!out_valid_q || out_ready) && (row_idx_q < IDX_W'(N_ROWS))) begin
          out_data_d  = w_row_q8;
          out_row_d   = w_row_sel;
          out_last_d  = (w_row_sel == ROW_W'(N_ROWS - 1));
          out_valid_d = 1'b1;
          row_idx_d   = row_idx_q + IDX_W'(1);
          sat_count_d = (w_sat_sum > 17'h0FFFF) ? 16'hFFFF : w_sat_sum[15:0];
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (out_valid_q && out_ready && out_last_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously so a reset aborts a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mult_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      row_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mult_q      <= mult_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      row_idx_q   <= row_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Tile snapshot: wide data register with no reset, loaded only on an accepted start.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      snapshot_q <= acc_flat;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain_quant.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_drain_quant
// Description : Directed self-checking bench for systolic_drain_quant on a
//               4x4 tile with hand-computed INT8 results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_drain_quant;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int RW = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [NR*NC*32-1:0] acc_flat;
  logic [15:0]      scale_mult;
  logic [4:0]       scale_shift;
  logic             relu_en;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [NC*8-1:0]  out_data;
  logic [RW-1:0]    out_row;
  logic             out_last;
  logic [15:0]      sat_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_row [NR];

  systolic_drain_quant #(.N_ROWS(NR), .N_COLS(NC), .ROW_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .acc_flat   (acc_flat),
    .scale_mult (scale_mult),
    .scale_shift(scale_shift),
    .relu_en    (relu_en),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_last   (out_last),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk4(input int a, input int b, input int c, input int d);
    logic [31:0] v;
    v = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return v;
  endfunction

  task automatic put(input int r, input int c, input int v);
    acc_flat[(r*NC + c)*32 +: 32] = v[31:0];
  endtask

  task automatic load_ramp();
    acc_flat = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) put(r, c, r*4 + c);
      exp_row[r] = mk4(4*r, 4*r+1, 4*r+2, 4*r+3);
    end
  endtask

  // Pulse start for one cycle; afterwards the bench sits in cycle k+1.
  task automatic start_tile(input logic [15:0] m, input logic [4:0] sh, input logic relu);
    scale_mult  = m;
    scale_shift = sh;
    relu_en     = relu;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_k1", out_valid, 0);
  endtask

  // Drain with out_ready held high: rows on consecutive cycles, then done.
  task automatic expect_rows_fast(input string tag);
    for (int r = 0; r < NR; r++) begin
      tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_row"}, out_row, r);
      chk({tag, "_data"}, out_data, exp_row[r]);
      chk({tag, "_last"}, out_last, (r == NR-1));
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_valid_off"}, out_valid, 0);
    tick();
    chk({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    int         next_row;
    int         done_cnt;
    logic [5:0] pat;

    rst_n = 1'b0; start = 1'b0; acc_flat = '0; scale_mult = 16'd1;
    scale_shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sat", sat_count, 0);
    #2 rst_n = 1'b1;
    tick();

    // Identity requant of a ramp tile.
    load_ramp();
    start_tile(16'd1, 5'd0, 1'b0);
    expect_rows_fast("ramp");
    chk("ramp_sat", sat_count, 0);

    // Saturation without ReLU, then with ReLU.
    acc_flat = '0;
    put(0, 0, -300); put(0, 1, 300); put(0, 2, 5); put(0, 3, -5);
    exp_row[0] = 32'hFB057F80;
    for (int r = 1; r < NR; r++) exp_row[r] = 32'h0;
    start_tile(16'd1, 5'd0, 1'b0);
    expect_rows_fast("sat");
    chk("sat_count2", sat_count, 2);
    exp_row[0] = 32'h00057F00;
    start_tile(16'd1, 5'd0, 1'b1);
    expect_rows_fast("relu");
    chk("relu_sat1", sat_count, 1);

    // Rounding shift with scale 3, shift 2.
    acc_flat = '0;
    put(0, 0, 5); put(0, 1, -5); put(0, 2, 6); put(0, 3, 0);
    put(1, 0, 100); put(1, 1, -100); put(1, 2, 2); put(1, 3, 1);
    exp_row[0] = 32'h0005FC04;
    exp_row[1] = 32'h0102B54B;
    exp_row[2] = 32'h0;
    exp_row[3] = 32'h0;
    start_tile(16'd3, 5'd2, 1'b0);
    expect_rows_fast("round");
    chk("round_sat", sat_count, 0);

    // Backpressure pattern 1,0,0,1,0,1 then ready held high.
    load_ramp();
    start_tile(16'd1, 5'd0, 1'b0);
    pat      = 6'b101001;
    next_row = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      out_ready = (i < 6) ? pat[i] : 1'b1;
      if (done) done_cnt++;
      if (out_valid) begin
        if (next_row < NR) begin
          chk("bp_row", out_row, next_row);
          chk("bp_data", out_data, exp_row[next_row]);
          chk("bp_last", out_last, (next_row == NR-1));
        end else begin
          chk("bp_extra_beat", next_row, NR-1);
        end
        if (out_ready) next_row++;
      end
    end
    chk("bp_rows_total", next_row, NR);
    chk("bp_done_pulses", done_cnt, 1);
    out_ready = 1'b1;

    // Start while busy is ignored; start the cycle after done is accepted.
    load_ramp();
    start_tile(16'd1, 5'd0, 1'b0);
    tick();
    chk("ign_row0", out_data, exp_row[0]);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) put(r, c, 100);
    scale_mult = 16'd2; scale_shift = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_row1", out_data, exp_row[1]);
    tick();
    chk("ign_row2", out_data, exp_row[2]);
    tick();
    chk("ign_row3", out_data, exp_row[3]);
    chk("ign_last", out_last, 1);
    tick();
    chk("ign_done", done, 1);
    tick();
    for (int r = 0; r < NR; r++) exp_row[r] = 32'h64646464;
    start_tile(16'd2, 5'd1, 1'b0);
    expect_rows_fast("after_done");

    // Asynchronous reset while row 2 is pending.
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) put(r, c, 300);
      exp_row[r] = 32'h7F7F7F7F;
    end
    start_tile(16'd1, 5'd0, 1'b0);
    tick(); tick(); tick();
    out_ready = 1'b0;
    chk("arst_pending_row", out_row, 2);
    chk("arst_pending_sat", sat_count, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sat", sat_count, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    start_tile(16'd1, 5'd0, 1'b0);
    expect_rows_fast("post_rst");
    chk("post_rst_sat", sat_count, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
